// File: rtl/stopwatch_counter_if.sv
// Pushbutton / 100 Hz inputs and MM:SS.CC display outputs of the stopwatch.
interface stopwatch_counter_if;
  logic       CLK_100Hz;
  logic       start_stop_n;
  logic       lap_n;
  logic       clear_n;
  logic [3:0] cs_ones;
  logic [3:0] cs_tens;
  logic [3:0] s_ones;
  logic [3:0] s_tens;
  logic [3:0] m_ones;
  logic [3:0] m_tens;
  logic       running;
  logic       lap_active;
  logic       overflow;

  modport master (
    output CLK_100Hz, start_stop_n, lap_n, clear_n,
    input  cs_ones, cs_tens, s_ones, s_tens, m_ones, m_tens,
    input  running, lap_active, overflow
  );

  modport slave (
    input  CLK_100Hz, start_stop_n, lap_n, clear_n,
    output cs_ones, cs_tens, s_ones, s_tens, m_ones, m_tens,
    output running, lap_active, overflow
  );
endinterface

// File: rtl/stopwatch_counter.sv
// MM:SS.CC stopwatch: synchronised 100 Hz tick and buttons, run/stop/lap FSM,
// BCD live counter with a lap-freeze display register and sticky overflow.
module stopwatch_counter #(
  parameter int SYNC_STAGES = 2
) (
  input logic                CLK_50MHz,
  input logic                reset_n,
  stopwatch_counter_if.slave sw
);

  localparam int BTN_START = 0;
  localparam int BTN_LAP   = 1;
  localparam int BTN_CLEAR = 2;
  localparam logic [2:0] SETTLE_COUNT = 3'(SYNC_STAGES);
  localparam logic [5:0][3:0] DIGIT_MAX = {4'd5, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9};

  typedef enum logic [1:0] {
    STOPPED = 2'd0,
    RUNNING = 2'd1,
    LAP     = 2'd2
  } state_t;

  state_t                       state_q, state_d;
  logic [SYNC_STAGES-1:0]       clk_sync_q;
  logic                         clk_prev_q;
  logic [2:0][SYNC_STAGES-1:0]  btn_sync_q;
  logic [2:0]                   btn_raw, btn_synced, btn_prev_q, btn_armed_q, press;
  logic [2:0]                   settle_cnt_q;
  logic                         settled, tick, count_en, lap_capture, carry, wrap;
  logic [5:0][3:0]              live, live_inc, lap_hold, shown;
  logic                         overflow_q;

  assign btn_raw = {sw.clear_n, sw.lap_n, sw.start_stop_n};
  assign settled = (settle_cnt_q == SETTLE_COUNT);

  // A button only arms once the chain holds real samples and shows it released,
  // so a button already held at reset release cannot fire until pressed again.
  always_ff @(posedge CLK_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_q   <= '0;
      clk_prev_q   <= 1'b0;
      btn_sync_q   <= '1;
      btn_prev_q   <= '1;
      btn_armed_q  <= '0;
      settle_cnt_q <= '0;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], sw.CLK_100Hz};
      clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
      for (int i = 0; i < 3; i++) begin
        btn_sync_q[i] <= {btn_sync_q[i][SYNC_STAGES-2:0], btn_raw[i]};
      end
      btn_prev_q <= btn_synced;
      if (!settled) begin
        settle_cnt_q <= settle_cnt_q + 3'd1;
      end
      btn_armed_q <= btn_armed_q | ({3{settled}} & btn_synced);
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      btn_synced[i] = btn_sync_q[i][SYNC_STAGES-1];
    end
  end

  assign press = btn_armed_q & btn_prev_q & ~btn_synced;
  assign tick  = clk_sync_q[SYNC_STAGES-1] & ~clk_prev_q;

  always_ff @(posedge CLK_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= STOPPED;
    end else begin
      state_q <= state_d;
    end
  end

  // Priority clear > start_stop > lap; lower-priority presses are dropped.
  always_comb begin
    state_d     = state_q;
    count_en    = tick && (state_q != STOPPED);
    lap_capture = 1'b0;
    if (press[BTN_CLEAR]) begin
      state_d = STOPPED;
    end else if (press[BTN_START]) begin
      state_d = (state_q == STOPPED) ? RUNNING : STOPPED;
    end else if (press[BTN_LAP]) begin
      case (state_q)
        RUNNING: begin
          state_d     = LAP;
          lap_capture = 1'b1;
        end
        LAP:     state_d = RUNNING;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    live_inc = live;
    carry    = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (carry) begin
        if (live[i] >= DIGIT_MAX[i]) begin
          live_inc[i] = 4'd0;
        end else begin
          live_inc[i] = live[i] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    wrap = carry;
  end

  // Lap capture takes the pre-tick live value; clear overrides any coincident tick.
  always_ff @(posedge CLK_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      live       <= '0;
      lap_hold   <= '0;
      overflow_q <= 1'b0;
    end else if (press[BTN_CLEAR]) begin
      live       <= '0;
      lap_hold   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (count_en) begin
        live <= live_inc;
        if (wrap) begin
          overflow_q <= 1'b1;
        end
      end
      if (lap_capture) begin
        lap_hold <= live;
      end
    end
  end

  assign shown         = (state_q == LAP) ? lap_hold : live;
  assign sw.cs_ones    = shown[0];
  assign sw.cs_tens    = shown[1];
  assign sw.s_ones     = shown[2];
  assign sw.s_tens     = shown[3];
  assign sw.m_ones     = shown[4];
  assign sw.m_tens     = shown[5];
  assign sw.running    = (state_q != STOPPED);
  assign sw.lap_active = (state_q == LAP);
  assign sw.overflow   = overflow_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter; display values are compared as MMSSCC hex.
module tb_stopwatch_counter;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  int   n_cmp   = 0;
  int   n_err   = 0;

  stopwatch_counter_if sw();

  stopwatch_counter #(.SYNC_STAGES(2)) dut (
    .CLK_50MHz (clk),
    .reset_n   (reset_n),
    .sw        (sw)
  );

  always #10 clk = ~clk;

  function automatic logic [23:0] display_value();
    return {sw.m_tens, sw.m_ones, sw.s_tens, sw.s_ones, sw.cs_tens, sw.cs_ones};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_output(input string tag, input logic [23:0] exp_disp,
                              input logic exp_run, input logic exp_lap, input logic exp_ovf);
    check({tag, ".disp"}, 32'(display_value()), 32'(exp_disp));
    check({tag, ".running"}, 32'(sw.running), 32'(exp_run));
    check({tag, ".lap_active"}, 32'(sw.lap_active), 32'(exp_lap));
    check({tag, ".overflow"}, 32'(sw.overflow), 32'(exp_ovf));
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      sw.CLK_100Hz = 1'b1;
      wait_cycles(2);
      sw.CLK_100Hz = 1'b0;
      wait_cycles(2);
    end
  endtask

  // mask bits: [2] clear, [1] lap, [0] start_stop; presses and tick launch together
  task automatic apply_stimulus(input logic [2:0] mask, input logic with_tick);
    sw.clear_n      = ~mask[2];
    sw.lap_n        = ~mask[1];
    sw.start_stop_n = ~mask[0];
    sw.CLK_100Hz    = with_tick;
    wait_cycles(2);
    sw.CLK_100Hz    = 1'b0;
    wait_cycles(2);
    sw.clear_n      = 1'b1;
    sw.lap_n        = 1'b1;
    sw.start_stop_n = 1'b1;
    wait_cycles(4);
  endtask

  initial begin
    #(20 * 90000);
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    sw.CLK_100Hz    = 1'b0;
    sw.start_stop_n = 1'b1;
    sw.lap_n        = 1'b1;
    sw.clear_n      = 1'b1;
    #1 reset_n = 1'b0;
    #4 check_output("reset", 24'h000000, 1'b0, 1'b0, 1'b0);
    wait_cycles(3);
    reset_n = 1'b1;
    wait_cycles(4);

    // lap and ticks are ignored while stopped
    apply_stimulus(3'b010, 1'b0);
    check_output("lap_in_stopped", 24'h000000, 1'b0, 1'b0, 1'b0);
    apply_ticks(1);
    check_output("tick_in_stopped", 24'h000000, 1'b0, 1'b0, 1'b0);

    apply_stimulus(3'b001, 1'b0);
    apply_ticks(100);
    check_output("one_second", 24'h000100, 1'b1, 1'b0, 1'b0);

    // count lands on the 3rd rising edge after the 100 Hz edge
    sw.CLK_100Hz = 1'b1;
    wait_cycles(2);
    check_output("latency_edge2", 24'h000100, 1'b1, 1'b0, 1'b0);
    wait_cycles(1);
    check_output("latency_edge3", 24'h000101, 1'b1, 1'b0, 1'b0);
    sw.CLK_100Hz = 1'b0;
    wait_cycles(2);

    apply_ticks(5898);
    check_output("at_59_99", 24'h005999, 1'b1, 1'b0, 1'b0);
    apply_ticks(1);
    check_output("minute_carry", 24'h010000, 1'b1, 1'b0, 1'b0);

    apply_stimulus(3'b001, 1'b0);
    apply_ticks(1);
    check_output("stopped_hold", 24'h010000, 1'b0, 1'b0, 1'b0);
    apply_stimulus(3'b100, 1'b0);
    check_output("clear_stopped", 24'h000000, 1'b0, 1'b0, 1'b0);

    // start beats lap when both are pressed together
    apply_stimulus(3'b011, 1'b0);
    check_output("start_lap_prio", 24'h000000, 1'b1, 1'b0, 1'b0);

    apply_ticks(250);
    apply_stimulus(3'b010, 1'b0);
    check_output("lap_enter", 24'h000250, 1'b1, 1'b1, 1'b0);
    apply_ticks(50);
    check_output("lap_frozen", 24'h000250, 1'b1, 1'b1, 1'b0);
    apply_stimulus(3'b010, 1'b0);
    check_output("lap_release", 24'h000300, 1'b1, 1'b0, 1'b0);

    apply_stimulus(3'b010, 1'b0);
    apply_ticks(10);
    check_output("lap_again", 24'h000300, 1'b1, 1'b1, 1'b0);
    apply_stimulus(3'b001, 1'b0);
    check_output("lap_to_stop", 24'h000310, 1'b0, 1'b0, 1'b0);

    apply_stimulus(3'b100, 1'b0);
    apply_stimulus(3'b001, 1'b0);
    apply_ticks(500);
    check_output("five_seconds", 24'h000500, 1'b1, 1'b0, 1'b0);
    apply_stimulus(3'b101, 1'b1);
    check_output("clear_start_tick", 24'h000000, 1'b0, 1'b0, 1'b0);

    // a tick on a state-change edge follows the pre-edge state
    apply_stimulus(3'b001, 1'b0);
    apply_ticks(5);
    apply_stimulus(3'b001, 1'b1);
    check_output("stop_with_tick", 24'h000006, 1'b0, 1'b0, 1'b0);
    apply_stimulus(3'b001, 1'b1);
    check_output("start_with_tick", 24'h000006, 1'b1, 1'b0, 1'b0);
    apply_ticks(1);
    apply_stimulus(3'b011, 1'b0);
    check_output("stop_lap_prio", 24'h000007, 1'b0, 1'b0, 1'b0);

    apply_stimulus(3'b100, 1'b0);
    dut.live = 24'h595999;
    wait_cycles(1);
    check_output("preload_max", 24'h595999, 1'b0, 1'b0, 1'b0);
    apply_stimulus(3'b001, 1'b0);
    apply_ticks(1);
    check_output("wrap", 24'h000000, 1'b1, 1'b0, 1'b1);
    apply_ticks(1);
    check_output("overflow_sticky", 24'h000001, 1'b1, 1'b0, 1'b1);
    apply_stimulus(3'b100, 1'b0);
    check_output("overflow_clear", 24'h000000, 1'b0, 1'b0, 1'b0);

    dut.live = 24'h123456;
    apply_stimulus(3'b001, 1'b0);
    apply_ticks(1);
    check_output("preload_run", 24'h123457, 1'b1, 1'b0, 1'b0);
    sw.CLK_100Hz = 1'b1;
    wait_cycles(1);
    #3 reset_n = 1'b0;
    #1 check_output("async_reset", 24'h000000, 1'b0, 1'b0, 1'b0);
    wait_cycles(2);
    reset_n = 1'b1;
    sw.CLK_100Hz = 1'b0;
    wait_cycles(2);
    check_output("after_reset", 24'h000000, 1'b0, 1'b0, 1'b0);
    apply_ticks(3);
    check_output("no_count_after_reset", 24'h000000, 1'b0, 1'b0, 1'b0);
    apply_stimulus(3'b001, 1'b0);
    apply_ticks(1);
    check_output("restart", 24'h000001, 1'b1, 1'b0, 1'b0);

    // button held through reset release must not fire
    sw.start_stop_n = 1'b0;
    #2 reset_n = 1'b0;
    wait_cycles(2);
    reset_n = 1'b1;
    wait_cycles(10);
    check_output("held_at_reset", 24'h000000, 1'b0, 1'b0, 1'b0);
    sw.start_stop_n = 1'b1;
    wait_cycles(6);
    check_output("held_released", 24'h000000, 1'b0, 1'b0, 1'b0);
    apply_stimulus(3'b001, 1'b0);
    apply_ticks(1);
    check_output("held_repressed", 24'h000001, 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stopwatch_counter.md
STOPWATCH_COUNTER -- requirements
Module: stopwatch_counter

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the number of flops (2..4) in each input synchroniser.
REQ-002 SHALL have port CLK_50MHz, input, 1, the single system clock; all state is clocked on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port CLK_100Hz, input, 1, the 100 Hz square wave from the clock divider, treated as asynchronous.
REQ-005 SHALL have port start_stop_n, input, 1, active-low debounced pushbutton that toggles run/stop.
REQ-006 SHALL have port lap_n, input, 1, active-low debounced pushbutton that freezes/releases the display.
REQ-007 SHALL have port clear_n, input, 1, active-low debounced pushbutton that zeroes the count.
REQ-008 SHALL have ports cs_ones, cs_tens, s_ones, s_tens, m_ones, m_tens, each output, 4, BCD display digits for MM:SS.CC.
REQ-009 SHALL have port running, output, 1, high in RUNNING or LAP.
REQ-010 SHALL have port lap_active, output, 1, high in LAP.
REQ-011 SHALL have port overflow, output, 1, sticky flag for wrap past 59:59.99.

Function
REQ-012 SHALL pass CLK_100Hz, start_stop_n, lap_n and clear_n each through a SYNC_STAGES-flop synchroniser before any use.
REQ-013 SHALL generate a one-cycle tick when the synchronised CLK_100Hz is 1 and its previous-cycle value is 0.
REQ-014 SHALL generate one-cycle press pulses on synchronised 1->0 transitions of each button; a held button SHALL give exactly one pulse.
REQ-015 SHALL count in the live register only when a tick occurs and the state is RUNNING or LAP.
REQ-016 SHALL, with SYNC_STAGES=2, update the live count on the 3rd CLK_50MHz rising edge after the CLK_100Hz rising edge.
REQ-017 SHALL count cs_ones 0-9, cs_tens 0-9, s_ones 0-9, s_tens 0-5, m_ones 0-9 and m_tens 0-5, with each digit carrying to the next on wrap.
REQ-018 SHALL wrap 59:59.99 to 00:00.00 on the next counted tick and set overflow=1 on that same edge.
REQ-019 SHALL implement the states STOPPED, RUNNING and LAP.
REQ-020 SHALL define the transitions as: STOPPED+start_stop->RUNNING; RUNNING+start_stop->STOPPED; RUNNING+lap->LAP; LAP+lap->RUNNING; LAP+start_stop->STOPPED.
REQ-021 SHALL ignore a lap press in STOPPED.
REQ-022 SHALL, on a clear press in any state, zero the live and display registers, clear overflow and go to STOPPED on the same edge.
REQ-023 SHALL drive the display digits from the live register in STOPPED and RUNNING, with zero added latency.
REQ-024 SHALL load the display register with the live value on the RUNNING->LAP edge and hold it while in LAP, while the live count continues.
REQ-025 SHALL give priority clear > start_stop > lap when presses coincide; the lower-priority presses in that cycle SHALL be discarded.
REQ-026 SHALL, when a tick coincides with a state change, count that tick according to the state before the edge.
REQ-027 SHALL, when clear coincides with a tick, leave the result 00:00.00.
REQ-028 SHALL never hold a BCD digit above its maximum value, in any state.

Reset
REQ-029 SHALL, on assertion of reset_n, immediately and asynchronously set state=STOPPED, all digits=0, running=0, lap_active=0 and overflow=0.
REQ-030 SHALL reset all synchroniser and edge-detect flops to the idle level: 0 for CLK_100Hz, 1 for the buttons.
REQ-031 SHALL ignore any button already held low at reset release until it has been released and pressed again.
REQ-032 SHALL, if reset is asserted mid-count, abort the count with no partial digit update.

Verification
REQ-033 SHALL verify: reset, then one start_stop press, then 100 CLK_100Hz periods -> display 00:01.00, running=1.
REQ-034 SHALL verify: preload to 00:59.99 by ticking while RUNNING, then one tick -> 01:00.00.
REQ-035 SHALL verify: reach 59:59.99, then one tick -> 00:00.00 with overflow=1, then a clear press -> overflow=0.
REQ-036 SHALL verify: lap pressed at 00:02.50, then 50 ticks -> display 00:02.50, lap_active=1; second lap press -> display 00:03.00.
REQ-037 SHALL verify: clear, start_stop and tick in the same cycle while RUNNING at 00:05.00 -> 00:00.00, STOPPED.
REQ-038 SHALL verify: reset_n pulsed low while RUNNING at 12:34.56 -> all outputs 0 immediately, no tick counted until the next start_stop press.
